// File: rtl/irq_prio_ctrl_pkg.sv
// Shared definitions for the registered priority interrupt controller.
//   irq_state_e : handshake FSM states (IDLE / PRESENT / SERVICE)
//   id_width    : width of a channel index (minimum 1 bit)
//   lvl_width   : width of a level index (minimum 1 bit)
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  function automatic int id_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int lvl_width(input int num_lvl);
    return (num_lvl <= 1) ? 1 : $clog2(num_lvl);
  endfunction

endpackage

// File: rtl/irq_prio_ctrl_enc.sv
// prio_enc: lowest-index-first priority encoder.
//   req   in  W   request vector
//   found out 1   any request bit set
//   idx   out IW  index of the lowest set bit (0 when nothing is set)
module prio_enc #(
  parameter int W  = 9,
  parameter int IW = 4
) (
  input  logic [W-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl: registered priority interrupt controller.
// Captures NUM_LVL x NUM_CH request lines, masks them with a per-channel
// enable, picks one winner (lowest level first, then lowest channel) and
// runs a present / acknowledge / end-of-interrupt handshake with a master.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   irq_req     request lines, bit l*NUM_CH+c = level l, channel c
//   ch_en       per-channel enable, applied at every level
//   irq_ack     master accepts the presented interrupt
//   irq_eoi     master finishes service
//   irq_valid   an interrupt is presented
//   irq_lvl     level of the presented / in-service interrupt
//   irq_id      channel of the presented / in-service interrupt
//   in_service  acknowledged interrupt awaiting EOI
//   lvl_pend    per level: any enabled pending request (registered)
//
// Handshake: irq_valid is the "valid" of a valid/ready pair and irq_ack its
// "ready"; a transfer happens on a clock edge where both are high. While
// valid is high, irq_lvl/irq_id are frozen. Valid may drop without a
// transfer only when the presented request stops being eligible (channel
// disabled or, in level mode, request withdrawn). After a transfer the
// controller stays in service until irq_eoi; there is no preemption.
module irq_prio_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_CH    = 9,
  parameter int NUM_LVL   = 3,
  parameter bit EDGE_MODE = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_LVL*NUM_CH-1:0]         irq_req,
  input  logic [NUM_CH-1:0]                 ch_en,
  input  logic                              irq_ack,
  input  logic                              irq_eoi,
  output logic                              irq_valid,
  output logic [lvl_width(NUM_LVL)-1:0]     irq_lvl,
  output logic [id_width(NUM_CH)-1:0]       irq_id,
  output logic                              in_service,
  output logic [NUM_LVL-1:0]                lvl_pend
);

  localparam int LW = lvl_width(NUM_LVL);
  localparam int IW = id_width(NUM_CH);
  localparam int NB = NUM_LVL * NUM_CH;

  irq_state_e                   state;
  logic [NB-1:0]                req_q;
  logic [NB-1:0]                pend;
  logic [NB-1:0]                elig;
  logic [NB-1:0]                cur_mask;
  logic                         cur_elig;
  logic                         ack_take;
  logic [NUM_LVL-1:0]           lvl_found;
  logic [NUM_LVL-1:0][IW-1:0]   lvl_idx;
  logic                         any_elig;
  logic [LW-1:0]                win_lvl;
  logic [IW-1:0]                win_id;

  // Previous request value; in level mode this is also the pending vector.
  always_ff @(posedge clk) begin
    if (rst) req_q <= '0;
    else     req_q <= irq_req;
  end

  generate
    if (EDGE_MODE) begin : g_edge
      // A fresh rising edge re-arms a bit even in the cycle it is acked.
      always_ff @(posedge clk) begin
        if (rst) pend <= '0;
        else     pend <= (pend & ~(ack_take ? cur_mask : '0)) | (irq_req & ~req_q);
      end
    end else begin : g_level
      assign pend = req_q;
    end
  endgenerate

  always_comb begin
    elig = '0;
    for (int l = 0; l < NUM_LVL; l++) begin
      elig[l*NUM_CH +: NUM_CH] = pend[l*NUM_CH +: NUM_CH] & ch_en;
    end
  end

  // One-hot of the currently latched level/channel, used both to test
  // whether the presented request is still eligible and to clear it on ack.
  always_comb begin
    cur_mask = '0;
    for (int l = 0; l < NUM_LVL; l++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cur_mask[l*NUM_CH + c] = (irq_lvl == LW'(l)) && (irq_id == IW'(c));
      end
    end
  end

  assign cur_elig = |(elig & cur_mask);
  assign ack_take = (state == PRESENT) && cur_elig && irq_ack;

  generate
    for (genvar l = 0; l < NUM_LVL; l++) begin : g_lvl_enc
      prio_enc #(.W(NUM_CH), .IW(IW)) u_ch_enc (
        .req   (elig[l*NUM_CH +: NUM_CH]),
        .found (lvl_found[l]),
        .idx   (lvl_idx[l])
      );
    end
  endgenerate

  prio_enc #(.W(NUM_LVL), .IW(LW)) u_lvl_enc (
    .req   (lvl_found),
    .found (any_elig),
    .idx   (win_lvl)
  );

  always_comb begin
    win_id = '0;
    for (int l = 0; l < NUM_LVL; l++) begin
      if (win_lvl == LW'(l)) win_id = lvl_idx[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      irq_lvl  <= '0;
      irq_id   <= '0;
      lvl_pend <= '0;
    end else begin
      lvl_pend <= lvl_found;
      case (state)
        IDLE: begin
          if (any_elig) begin
            irq_lvl <= win_lvl;
            irq_id  <= win_id;
            state   <= PRESENT;
          end
        end
        PRESENT: begin
          if (!cur_elig)    state <= IDLE;
          else if (irq_ack) state <= SERVICE;
        end
        SERVICE: begin
          if (irq_eoi) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign irq_valid  = (state == PRESENT);
  assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Bench for irq_prio_ctrl: one edge-mode and one level-mode instance share
// the stimulus; presentations of the edge-mode instance are scored against
// an expected queue of {level, channel} values.
module tb_irq_prio_ctrl;
  import irq_pkg::*;

  localparam int NUM_CH  = 9;
  localparam int NUM_LVL = 3;
  localparam int LW      = 2;
  localparam int IW      = 4;
  localparam int W       = LW + IW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_LVL*NUM_CH-1:0] irq_req = '0;
  logic [NUM_CH-1:0]         ch_en   = '0;
  logic                      irq_ack = 1'b0;
  logic                      irq_eoi = 1'b0;

  logic               e_valid, e_insvc, l_valid, l_insvc;
  logic [LW-1:0]      e_lvl, l_lvl;
  logic [IW-1:0]      e_id, l_id;
  logic [NUM_LVL-1:0] e_pend, l_pend;

  irq_prio_ctrl #(.NUM_CH(NUM_CH), .NUM_LVL(NUM_LVL), .EDGE_MODE(1'b1)) dut_e (
    .clk(clk), .rst(rst), .irq_req(irq_req), .ch_en(ch_en),
    .irq_ack(irq_ack), .irq_eoi(irq_eoi), .irq_valid(e_valid),
    .irq_lvl(e_lvl), .irq_id(e_id), .in_service(e_insvc), .lvl_pend(e_pend)
  );

  irq_prio_ctrl #(.NUM_CH(NUM_CH), .NUM_LVL(NUM_LVL), .EDGE_MODE(1'b0)) dut_l (
    .clk(clk), .rst(rst), .irq_req(irq_req), .ch_en(ch_en),
    .irq_ack(irq_ack), .irq_eoi(irq_eoi), .irq_valid(l_valid),
    .irq_lvl(l_lvl), .irq_id(l_id), .in_service(l_insvc), .lvl_pend(l_pend)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks (all driving and sampling happens at the falling edge)
  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_req(input logic [NUM_LVL*NUM_CH-1:0] bits);
    irq_req = bits;
    step();
    irq_req = '0;
  endtask

  task automatic expect_present(input string tag);
    logic [W-1:0] e;
    int n = 0;
    while (!e_valid && n < 16) begin
      step();
      n++;
    end
    if (!e_valid) begin
      check_eq({tag, "_timeout"}, 32'(e_valid), 32'd1);
    end else if (exp_q.size() == 0) begin
      check_eq({tag, "_unexpected"}, 32'(e_valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 32'({e_lvl, e_id}), 32'(e));
    end
  endtask

  task automatic do_ack(input string tag);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check_eq({tag, "_ack_insvc"}, 32'(e_insvc), 32'd1);
    check_eq({tag, "_ack_valid"}, 32'(e_valid), 32'd0);
  endtask

  task automatic do_eoi(input string tag);
    irq_eoi = 1'b1;
    step();
    irq_eoi = 1'b0;
    check_eq({tag, "_eoi_insvc"}, 32'(e_insvc), 32'd0);
  endtask

  function automatic logic [W-1:0] li(input int lvl, input int id);
    return {LW'(lvl), IW'(id)};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    // reset
    rst = 1'b1;
    repeat (3) step();
    check_eq("rst_valid",  32'(e_valid), 32'd0);
    check_eq("rst_insvc",  32'(e_insvc), 32'd0);
    check_eq("rst_lvlid",  32'({e_lvl, e_id}), 32'd0);
    check_eq("rst_pend",   32'(e_pend), 32'd0);
    check_eq("rst_state",  32'(dut_e.state), 32'(IDLE));
    check_eq("rst_lvalid", 32'(l_valid), 32'd0);
    rst   = 1'b0;
    ch_en = 9'h1FF;
    step();

    // two levels at once: level 0 wins, two-cycle latency
    exp_q.push_back(li(0, 5));
    exp_q.push_back(li(1, 1));
    irq_req = (27'd1 << 5) | (27'd1 << 10);
    step();
    irq_req = '0;
    check_eq("t1_lat1_valid", 32'(e_valid), 32'd0);
    check_eq("t1_lat1_pend",  32'(e_pend), 32'd0);
    step();
    check_eq("t1_lat2_valid", 32'(e_valid), 32'd1);
    check_eq("t1_lat2_pend",  32'(e_pend), 32'b011);
    expect_present("t1_first");
    do_ack("t1a");
    do_eoi("t1a");
    expect_present("t1_second");
    do_ack("t1b");
    do_eoi("t1b");
    repeat (3) step();
    check_eq("t1_idle_valid", 32'(e_valid), 32'd0);

    // same level: lowest channel first
    exp_q.push_back(li(0, 3));
    exp_q.push_back(li(0, 7));
    pulse_req((27'd1 << 3) | (27'd1 << 7));
    expect_present("t2_first");
    do_ack("t2a");
    do_eoi("t2a");
    expect_present("t2_second");
    do_ack("t2b");
    do_eoi("t2b");

    // disabled channel skipped; lower level presented
    ch_en = 9'h1F7;
    exp_q.push_back(li(2, 0));
    pulse_req((27'd1 << 3) | (27'd1 << 18));
    expect_present("t3_present");
    check_eq("t3_pend", 32'(e_pend), 32'b100);
    do_ack("t3");

    // no preemption while in service
    exp_q.push_back(li(0, 2));
    pulse_req(27'd1 << 2);
    repeat (3) step();
    check_eq("t4_insvc", 32'(e_insvc), 32'd1);
    check_eq("t4_valid", 32'(e_valid), 32'd0);
    check_eq("t4_hold",  32'({e_lvl, e_id}), 32'(li(2, 0)));
    do_eoi("t4");
    expect_present("t4_after_eoi");
    do_ack("t4b");
    do_eoi("t4b");

    // re-enabling the masked channel exposes its latched edge
    ch_en = 9'h1FF;
    exp_q.push_back(li(0, 3));
    expect_present("t4_reenabled");
    do_ack("t4c");
    do_eoi("t4c");

    // new edge on the presented bit in the ack cycle keeps it pending
    exp_q.push_back(li(1, 4));
    exp_q.push_back(li(1, 4));
    pulse_req(27'd1 << 13);
    expect_present("t5_first");
    irq_req = 27'd1 << 13;
    irq_ack = 1'b1;
    step();
    irq_req = '0;
    irq_ack = 1'b0;
    check_eq("t5_ack_insvc", 32'(e_insvc), 32'd1);
    do_eoi("t5");
    expect_present("t5_repeat");
    do_ack("t5b");
    do_eoi("t5b");

    // stray ack / eoi in IDLE
    repeat (2) step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    step();
    irq_eoi = 1'b0;
    step();
    check_eq("t5_stray_state", 32'(dut_e.state), 32'(IDLE));
    check_eq("t5_stray_valid", 32'(e_valid), 32'd0);
    check_eq("t5_stray_insvc", 32'(e_insvc), 32'd0);

    // level mode: reset mid-presentation, held request comes back
    rst = 1'b1;
    step();
    rst = 1'b0;
    irq_req = 27'd1 << 1;
    repeat (2) step();
    check_eq("t6_l_valid", 32'(l_valid), 32'd1);
    check_eq("t6_l_lvlid", 32'({l_lvl, l_id}), 32'(li(0, 1)));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t6_rst_lvalid", 32'(l_valid), 32'd0);
    check_eq("t6_rst_linsvc", 32'(l_insvc), 32'd0);
    check_eq("t6_rst_llvlid", 32'({l_lvl, l_id}), 32'd0);
    check_eq("t6_rst_lpend",  32'(l_pend), 32'd0);
    check_eq("t6_rst_lstate", 32'(dut_l.state), 32'(IDLE));
    check_eq("t6_rst_evalid", 32'(e_valid), 32'd0);
    step();
    check_eq("t6_re_lat1", 32'(l_valid), 32'd0);
    step();
    check_eq("t6_re_lat2",   32'(l_valid), 32'd1);
    check_eq("t6_re_lvlid",  32'({l_lvl, l_id}), 32'(li(0, 1)));
    check_eq("t6_re_pend",   32'(l_pend), 32'b001);
    irq_req = '0;
    repeat (2) step();

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_prio_ctrl.md
# irq_prio_ctrl

Parametrised, registered priority interrupt controller. It is the sequential successor of the combinational 27-input (3 levels × 9 channels) priority interrupt encoder in the benchmark set. It captures requests from NUM_LVL priority buses of NUM_CH channels each and masks them with a per-channel enable. It arbitrates one winner and runs a present / acknowledge / end-of-interrupt handshake with the serviced agent. It sits between peripheral request lines and a single interrupt-service master.

## Interface
- NUM_CH, 9, channels per priority level (1..32)
- NUM_LVL, 3, priority levels; level 0 is highest (1..8)
- EDGE_MODE, 0, 0 = level-sensitive requests, 1 = rising-edge capture into pending latches
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- irq_req  in  NUM_LVL*NUM_CH  request lines; bit l*NUM_CH+c is level l, channel c
- ch_en  in  NUM_CH  per-channel enable, applied at every level
- irq_ack  in  1  master accepts the presented interrupt
- irq_eoi  in  1  master finishes service
- irq_valid  out  1  an interrupt is presented
- irq_lvl  out  clog2(NUM_LVL) (min 1)  level of the presented or in-service interrupt
- irq_id  out  clog2(NUM_CH) (min 1)  channel of the presented or in-service interrupt
- in_service  out  1  an acknowledged interrupt is awaiting EOI
- lvl_pend  out  NUM_LVL  per level: any enabled pending request (registered)

## Operation
- Pending vector P (NUM_LVL*NUM_CH bits):
  - EDGE_MODE=1: a bit is set on a 0→1 transition of irq_req relative to its registered previous value. It is cleared by an ack of that bit. If set and clear hit the same bit in the same cycle, set wins.
  - EDGE_MODE=0: P = registered irq_req. Ack does not clear it.
- Eligible E = P & ch_en, replicated per level.
- Arbitration: the lowest level with any E bit wins. Within that level the lowest channel index wins.
- FSM states: IDLE, PRESENT, SERVICE. Reset enters IDLE.
  - IDLE: if any E bit is set, latch the winner into irq_lvl/irq_id and go to PRESENT.
  - PRESENT: irq_valid=1 and irq_lvl/irq_id are frozen. Re-arbitration happens only if the presented bit is no longer eligible (disabled or dropped in level mode); the FSM then returns to IDLE with no ack taken. On irq_ack, clear the presented pending bit (edge mode) and go to SERVICE.
  - SERVICE: in_service=1, irq_valid=0, irq_lvl/irq_id hold. On irq_eoi, go to IDLE. No preemption: higher-level requests wait.
- irq_ack outside PRESENT is ignored. irq_eoi outside SERVICE is ignored.
- Level mode: a requester still asserting at EOI is presented again.
- lvl_pend[l] = OR of E over level l, registered. It is independent of FSM state.

## Timing
- Reset values: irq_valid=0, in_service=0, irq_lvl=0, irq_id=0, lvl_pend=0, P=0, previous-request register=0, state IDLE.
- Request to irq_valid: 2 cycles in edge mode (edge capture, then arbitration latch). 2 cycles in level mode (sample, then latch).
- Ack sampled in PRESENT: next cycle in_service=1, irq_valid=0.
- EOI sampled in SERVICE: next cycle IDLE. The earliest next irq_valid is 1 cycle after that.
- Request to lvl_pend: 2 cycles.
- Reset asserted mid-handshake forces the reset values on the next edge. Pending edges are lost.

## Structure
- Package irq_pkg: state enum (IDLE/PRESENT/SERVICE), width helper functions for the id and level widths.
- Sub-module prio_enc: parametrised lowest-index-first priority encoder. It outputs found plus index. One instance is used per level, plus one instance over the per-level found vector.

## Test plan
Default parameters (NUM_CH=9, NUM_LVL=3) unless stated.

- EDGE_MODE=1, ch_en=0x1FF, pulse irq_req bits 5 (L0 ch5) and 10 (L1 ch1) together → irq_valid two cycles later with lvl=0, id=5. Ack, then EOI → next presentation lvl=1, id=1.
- Same level, ch3 and ch7 asserted → id=3 first. ch7 is presented after EOI.
- ch_en=0x1F7, request L0 ch3 and L2 ch0 → lvl=2, id=0 is presented. lvl_pend=3'b100.
- In SERVICE (L2 ch0), raise L0 ch2 → no preemption and in_service stays 1. After EOI, lvl=0, id=2 is presented.
- EDGE_MODE=1: a new edge on the presented bit in the same cycle as ack → bit stays pending and is re-presented after EOI. Stray irq_ack and irq_eoi in IDLE → no state change.
- Assert rst while in PRESENT → next cycle every output is 0 and the state is IDLE. In level mode, a held request is presented again 2 cycles after rst deasserts.
